// File: rtl/ifc_bundle_arb_slice_pkg.sv
// Shared helpers for the multi-channel x/y/z bundle arbiter slice.
// Holds the channel-index width helper and the even-parity function used by the block and the bench.
package ifc_bundle_pkg;

  // Parity operands are zero-extended to this width, which leaves their parity unchanged.
  localparam int PAR_MAX_BITS = 192;

  function automatic int ch_idx_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic logic even_parity(input logic [PAR_MAX_BITS-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ifc_bundle_arb_slice_if.sv
// Interface bundling NCH producer channels and the single consumer port of ifc_bundle_arb_slice.
// Parity ports exist only when IFC_BUNDLE_PARITY_EN is defined.
interface ifc_bundle_arb_slice_if #(
  parameter int NCH   = 4,
  parameter int W     = 1,
  parameter int DEPTH = 2
);
  import ifc_bundle_pkg::*;

  localparam int CHW = ch_idx_w(NCH);
  localparam int LVW = $clog2(DEPTH) + 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // the producer holds valid and data stable until then, and ready may depend on valid.
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic [NCH*W-1:0] in_x;
  logic [NCH*W-1:0] in_y;
  logic [NCH*W-1:0] in_z;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_x;
  logic [W-1:0]     out_y;
  logic [W-1:0]     out_z;
  logic [CHW-1:0]   out_ch;
  logic [LVW-1:0]   level;
`ifdef IFC_BUNDLE_PARITY_EN
  logic [NCH-1:0]   in_par;
  logic             out_par;
  logic             par_err;

  modport slave (
    input  in_valid, in_x, in_y, in_z, in_par, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, out_ch, level, out_par, par_err
  );
  modport master (
    output in_valid, in_x, in_y, in_z, in_par, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, out_ch, level, out_par, par_err
  );
`else
  modport slave (
    input  in_valid, in_x, in_y, in_z, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, out_ch, level
  );
  modport master (
    output in_valid, in_x, in_y, in_z, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, out_ch, level
  );
`endif

endinterface

// File: rtl/ifc_bundle_arb_slice_arbiter.sv
// Round-robin grant over NCH requesters; the pointer moves past the winner only when it is accepted.
module ifc_rr_arbiter
  import ifc_bundle_pkg::*;
#(
  parameter int NCH = 4,
  localparam int CHW = ch_idx_w(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] i_req,
  input  logic           i_advance,
  output logic [CHW-1:0] o_grant
);

  logic [CHW-1:0] r_ptr;
  logic [CHW-1:0] w_grant;
  logic [CHW-1:0] w_idx;

  function automatic logic [CHW-1:0] wrap_add(input logic [CHW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NCH) s = s - NCH;
    return CHW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    w_grant = r_ptr;
    w_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      w_idx = wrap_add(r_ptr, i);
      if (i_req[w_idx]) w_grant = w_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= wrap_add(w_grant, 1);
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/ifc_bundle_arb_slice.sv
// NCH-channel x/y/z bundle arbiter with a DEPTH-entry output FIFO and channel tag.
// Optional per-entry parity and sticky error flag under IFC_BUNDLE_PARITY_EN.
module ifc_bundle_arb_slice
  import ifc_bundle_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ifc_bundle_arb_slice_if.slave bus
);

  localparam int CHW = ch_idx_w(NCH);
  localparam int AW  = $clog2(DEPTH);
  localparam int LVW = AW + 1;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } bundle_t;

  bundle_t        r_mem    [DEPTH];
  logic [CHW-1:0] r_mem_ch [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [LVW-1:0] r_level;
  bundle_t        r_last;
  logic [CHW-1:0] r_last_ch;

  logic [CHW-1:0] w_grant;
  bundle_t        w_in;
  bundle_t        w_head;
  logic           w_out_valid;
  logic           w_pop;
  logic           w_space;
  logic           w_push;

  ifc_rr_arbiter #(.NCH(NCH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (bus.in_valid),
    .i_advance (w_push),
    .o_grant   (w_grant)
  );

  always_comb begin
    w_in.x = bus.in_x[w_grant*W +: W];
    w_in.y = bus.in_y[w_grant*W +: W];
    w_in.z = bus.in_z[w_grant*W +: W];
  end

  assign w_out_valid = (r_level != '0);
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_space     = (r_level < LVW'(DEPTH)) || w_pop;
  assign w_push      = !rst && w_space && bus.in_valid[w_grant];

  always_comb begin
    bus.in_ready = '0;
    if (!rst && w_space) bus.in_ready[w_grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_last    <= '0;
      r_last_ch <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr]    <= w_in;
        r_mem_ch[r_wr_ptr] <= w_grant;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      // The popped entry is kept so outputs hold their last value while empty.
      if (w_pop) begin
        r_last    <= r_mem[r_rd_ptr];
        r_last_ch <= r_mem_ch[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign w_head        = w_out_valid ? r_mem[r_rd_ptr] : r_last;
  assign bus.out_valid = w_out_valid;
  assign bus.out_x     = w_head.x;
  assign bus.out_y     = w_head.y;
  assign bus.out_z     = w_head.z;
  assign bus.out_ch    = w_out_valid ? r_mem_ch[r_rd_ptr] : r_last_ch;
  assign bus.level     = r_level;

`ifdef IFC_BUNDLE_PARITY_EN
  logic r_mem_par [DEPTH];
  logic r_last_par;
  logic r_par_err;
  logic w_in_par;

  assign w_in_par = even_parity(PAR_MAX_BITS'(w_in));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_par <= 1'b0;
      r_par_err  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_par[r_wr_ptr] <= w_in_par;
        if (bus.in_par[w_grant] != w_in_par) r_par_err <= 1'b1;
      end
      if (w_pop) r_last_par <= r_mem_par[r_rd_ptr];
    end
  end

  assign bus.out_par = w_out_valid ? r_mem_par[r_rd_ptr] : r_last_par;
  assign bus.par_err = r_par_err;
`endif

endmodule

// File: tb/tb_ifc_bundle_arb_slice.sv
// Bench for ifc_bundle_arb_slice: a spec-level model predicts grants, ready, level and the
// output order; a DEPTH=4 instance covers FIFO pointer wrap.
module tb_ifc_bundle_arb_slice;
  import ifc_bundle_pkg::*;

  localparam int NCH    = 4;
  localparam int W      = 1;
  localparam int DEPTH  = 2;
  localparam int CHW    = ch_idx_w(NCH);
  localparam int EW     = CHW + 3*W;
  localparam int W4     = 4;
  localparam int DEPTH4 = 4;
  localparam int EW4    = 3*W4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifc_bundle_arb_slice_if #(.NCH(NCH), .W(W),  .DEPTH(DEPTH))  bus  ();
  ifc_bundle_arb_slice_if #(.NCH(NCH), .W(W4), .DEPTH(DEPTH4)) bus4 ();

  ifc_bundle_arb_slice #(.NCH(NCH), .W(W), .DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ifc_bundle_arb_slice #(.NCH(NCH), .W(W4), .DEPTH(DEPTH4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [EW-1:0]  exp_q[$];
  logic [EW4-1:0] exp4_q[$];
  logic [EW-1:0]  m_last;
  int             m_level;
  int             m_ptr;
  logic           m_par_err;
  logic [NCH-1:0] keep;
  bit             rand_mode;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [NCH-1:0] v, input int ptr);
    for (int k = 0; k < NCH; k++) begin
      if (v[(ptr + k) % NCH]) return (ptr + k) % NCH;
    end
    return ptr;
  endfunction

  task automatic fix_par(input int c);
`ifdef IFC_BUNDLE_PARITY_EN
    bus.in_par[c] = even_parity(PAR_MAX_BITS'({bus.in_x[c*W +: W], bus.in_y[c*W +: W], bus.in_z[c*W +: W]}));
`else
    if (c < 0) $display("channel index below zero");
`endif
  endtask

  task automatic new_data(input int c);
    bus.in_x[c*W +: W] = W'($urandom);
    bus.in_y[c*W +: W] = W'($urandom);
    bus.in_z[c*W +: W] = W'($urandom);
    fix_par(c);
  endtask

  // One clock of the main instance: check outputs against the model at negedge, advance the
  // model, then after the edge update producers that were accepted.
  task automatic cycle();
    logic [NCH-1:0] exp_rdy;
    logic [EW-1:0]  head;
    int             g;
    bit             pop, space, acc;
    @(negedge clk);
    pop   = (m_level != 0) && bus.out_ready;
    space = (m_level < DEPTH) || pop;
    g     = model_grant(bus.in_valid, m_ptr);
    exp_rdy = '0;
    if (!rst && space) exp_rdy[g] = 1'b1;
    acc  = !rst && space && bus.in_valid[g];
    head = (m_level != 0) ? exp_q[0] : m_last;
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check("out_valid", 32'(bus.out_valid), 32'(m_level != 0));
    check("level", 32'(bus.level), m_level);
    check("out_entry", 32'({bus.out_ch, bus.out_x, bus.out_y, bus.out_z}), 32'(head));
`ifdef IFC_BUNDLE_PARITY_EN
    check("out_par", 32'(bus.out_par), 32'(even_parity(PAR_MAX_BITS'(head[3*W-1:0]))));
    check("par_err", 32'(bus.par_err), 32'(m_par_err));
    if (!rst && acc && (bus.in_par[g] != even_parity(PAR_MAX_BITS'({bus.in_x[g*W +: W], bus.in_y[g*W +: W], bus.in_z[g*W +: W]}))))
      m_par_err = 1'b1;
`endif
    if (rst) begin
      m_level = 0;
      m_ptr = 0;
      m_last = '0;
      m_par_err = 1'b0;
      exp_q.delete();
    end else begin
      if (pop) m_last = exp_q.pop_front();
      if (acc) begin
        exp_q.push_back({CHW'(g), bus.in_x[g*W +: W], bus.in_y[g*W +: W], bus.in_z[g*W +: W]});
        m_ptr = (g + 1) % NCH;
      end
      m_level = m_level + int'(acc) - int'(pop);
    end
    @(posedge clk);
    #1;
    if (acc) begin
      if (keep[g]) new_data(g);
      else bus.in_valid[g] = 1'b0;
    end
    if (rand_mode) begin
      for (int c = 0; c < NCH; c++) begin
        if (!bus.in_valid[c] && $urandom_range(0, 99) < 50) begin
          new_data(c);
          bus.in_valid[c] = 1'b1;
        end
      end
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic       xz_net;
    logic [3:0] d;
    int         sent;
    bit         pop4, space4, acc4;
    int         m4_level;

    rst = 1'b1;
    bus.in_valid = '0; bus.in_x = '0; bus.in_y = '0; bus.in_z = '0; bus.out_ready = 1'b0;
    bus4.in_valid = '0; bus4.in_x = '0; bus4.in_y = '0; bus4.in_z = '0; bus4.out_ready = 1'b0;
`ifdef IFC_BUNDLE_PARITY_EN
    bus.in_par = '0;
    bus4.in_par = '0;
`endif
    keep = '0; rand_mode = 0;
    m_level = 0; m_ptr = 0; m_last = '0; m_par_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;

    // Reset mid-stream: two entries buffered, rst for one cycle with a producer still valid.
    new_data(0);
    bus.in_valid[0] = 1'b1;
    keep[0] = 1'b1;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.in_valid = '0;
    keep = '0;
    cycle();

    // Round robin: every channel valid and refreshed after each accept.
    for (int c = 0; c < NCH; c++) new_data(c);
    bus.in_valid = '1;
    keep = '1;
    bus.out_ready = 1'b1;
    repeat (9) cycle();
    bus.in_valid = '0;
    keep = '0;
    repeat (3) cycle();

    // Full backpressure on channel 1, then simultaneous push and pop.
    bus.out_ready = 1'b0;
    new_data(1);
    bus.in_valid[1] = 1'b1;
    keep[1] = 1'b1;
    repeat (3) cycle();
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    bus.in_valid = '0;
    keep = '0;
    repeat (3) cycle();

    // Field integrity: x and z of channel 2 come from one net.
    for (int v = 0; v < 2; v++) begin
      xz_net = 1'(v);
      bus.in_x[2*W +: W] = xz_net;
      bus.in_z[2*W +: W] = xz_net;
      bus.in_y[2*W +: W] = ~xz_net;
      fix_par(2);
      bus.in_valid[2] = 1'b1;
      repeat (2) cycle();
    end

    // FIFO pointer wrap on the DEPTH=4 instance: 9 entries, alternating out_ready.
    d = 4'd1;
    sent = 0;
    m4_level = 0;
    bus4.in_x[W4-1:0] = d; bus4.in_y[W4-1:0] = ~d; bus4.in_z[W4-1:0] = d + 4'd3;
    bus4.in_valid[0] = 1'b1;
    for (int cyc = 0; cyc < 40 && (sent < 9 || m4_level > 0); cyc++) begin
      bus4.out_ready = (cyc % 2) == 1;
      @(negedge clk);
      pop4   = (m4_level > 0) && bus4.out_ready;
      space4 = (m4_level < DEPTH4) || pop4;
      acc4   = space4 && bus4.in_valid[0];
      if (bus4.in_valid[0]) check("wrap_in_ready", 32'(bus4.in_ready[0]), 32'(space4));
      check("wrap_level", 32'(bus4.level), m4_level);
      if (pop4) check("wrap_order", 32'({bus4.out_x, bus4.out_y, bus4.out_z}), 32'(exp4_q.pop_front()));
      if (acc4) exp4_q.push_back({bus4.in_x[W4-1:0], bus4.in_y[W4-1:0], bus4.in_z[W4-1:0]});
      m4_level = m4_level + int'(acc4) - int'(pop4);
      @(posedge clk);
      #1;
      if (acc4) begin
        sent++;
        d = d + 4'd1;
        bus4.in_x[W4-1:0] = d; bus4.in_y[W4-1:0] = ~d; bus4.in_z[W4-1:0] = d + 4'd3;
        if (sent == 9) bus4.in_valid[0] = 1'b0;
      end
    end
    bus4.out_ready = 1'b0;
    check("wrap_all_sent", 32'(sent), 32'd9);
    check("wrap_drained", 32'(bus4.level), 32'd0);

    // Random traffic with random backpressure.
    rand_mode = 1;
    repeat (150) cycle();
    rand_mode = 0;
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    repeat (4) cycle();

`ifdef IFC_BUNDLE_PARITY_EN
    // Deliberate parity mismatch: {1,1,1} has parity 1, sent with in_par=0.
    bus.in_x[0] = 1'b1; bus.in_y[0] = 1'b1; bus.in_z[0] = 1'b1;
    bus.in_par[0] = 1'b0;
    bus.in_valid[0] = 1'b1;
    repeat (5) cycle();
    check("par_err_sticky", 32'(bus.par_err), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("par_err_cleared", 32'(bus.par_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ifc_bundle_arb_slice.md
Name: ifc_bundle_arb_slice

Overview:
- Parametrised successor to the single-channel x/y/z interface bundle.
- Accepts NCH independent x/y/z bundles, each W bits per field, with valid/ready handshakes.
- Arbitrates round-robin and buffers winners in a DEPTH-entry FIFO.
- Presents one registered bundle plus channel tag to the downstream consumer; sits between bundle producers and a shared interface-port module.

Parameters:
- NCH, 4, number of input bundle channels (2..16).
- W, 1, width of each of the x, y, z fields.
- DEPTH, 2, output FIFO entries (2..8; power of two).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  NCH  per-channel bundle valid.
- in_ready  output  NCH  per-channel accept; at most one bit high per cycle.
- in_x  input  NCH*W  x fields; channel c occupies bits [c*W +: W]; same packing for in_y and in_z.
- in_y  input  NCH*W  y fields.
- in_z  input  NCH*W  z fields.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accept.
- out_x, out_y, out_z  output  W each  head entry fields.
- out_ch  output  $clog2(NCH)  source channel of the head entry.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset, synchronous and active-high, sampled on the clk edge:
  - FIFO empties.
  - Round-robin pointer goes to 0.
  - out_valid=0; out_x/out_y/out_z/out_ch=0; level=0.
  - in_ready is forced to all-zero while rst is high.
- Asserting rst mid-transfer discards all buffered entries. No partial entry is ever emitted.
- Arbitration:
  - Grant goes to the lowest-index requesting channel at or after ptr, wrapping modulo NCH.
  - A channel is accepted when in_valid[c]=1, grant==c and space is available.
  - space = (level<DEPTH) || (out_valid && out_ready).
  - in_ready[c] = (grant==c) && space && !rst. This is combinational from in_valid and out_ready, which is intended.
  - After an accept, ptr <= grant+1 (mod NCH). With no accept, ptr holds.
- Fairness: a channel holding valid continuously is accepted within NCH accepts.
- Handshake rules:
  - A producer must hold its valid and data stable until ready.
  - An entry is popped on out_valid && out_ready.
  - out_* come straight from FIFO storage registers; no combinational path exists from the in_* ports to out_*.
- Latency: an entry accepted in cycle N appears on out_* in cycle N+1 at the earliest.
- Full: when level==DEPTH and out_ready=0, all in_ready are 0.
- Full with simultaneous pop: push and pop in the same cycle are allowed; level stays the same.
- Empty: out_valid=0. out_* hold their last popped values (0 after reset).
- Level update: level increments on push-only, decrements on pop-only, and is unchanged otherwise.
- Pointer wrap: read/write pointers wrap modulo DEPTH.
- Field aliasing:
  - x, y and z are stored independently.
  - A producer that drives its x and z inputs from the same net must see identical out_x/out_z.
  - No field may be reordered or merged.

Optional Feature:
- Macro: IFC_BUNDLE_PARITY_EN.
- When defined:
  - Adds output out_par (1 bit), the even parity of {x,y,z} for the head entry, computed at push and stored per entry.
  - Adds input in_par (NCH bits). On accept, a mismatch between in_par[c] and the computed parity sets the sticky output par_err.
  - par_err is cleared only by rst.
- When undefined: no parity ports or storage exist; behaviour is otherwise identical.

Decomposition:
- Shared package ifc_bundle_pkg:
  - Parameterisable bundle struct type {x,y,z} of W-bit fields.
  - Localparam helper for channel-index width.
  - Parity function used by both block and bench.
- One sub-module, ifc_rr_arbiter: NCH-wide round-robin grant with ptr register and advance-on-accept input.
- The FIFO stays inline.

Test Plan:
- Reset mid-stream: fill 2 entries, assert rst 1 cycle -> next cycle out_valid=0, level=0, in_ready=0 during rst, out_x/y/z/out_ch=0.
- Round robin: NCH=4, all valid held, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 with one accept per cycle after the first output.
- Full backpressure: DEPTH=2, out_ready=0, ch1 valid -> two accepts, then in_ready=0 and level=2. Raise out_ready -> simultaneous pop and push, level stays 2.
- Field integrity: W=1, ch2 drives x=0, y=1, z=0 (x and z from the same net) -> out_x=0, out_y=1, out_z=0, out_ch=2, one cycle after accept.
- Wrap: DEPTH=4, push/pop 9 entries with alternating out_ready -> order preserved and no loss across pointer wrap.
- Parity (with IFC_BUNDLE_PARITY_EN): push {x=1,y=1,z=1} with in_par=0 -> par_err=1, remains set until rst.
